// File: rtl/ddc_out_formatter.sv
// Buffers decimated DDC I/Q pairs in a small FIFO and serialises them as I then Q words
// on one valid/ready output bus, with a sticky flag for pairs lost to a full buffer.
module ddc_out_formatter #(
  parameter int DATABITWIDTH = 16,
  parameter int FIFODEPTH    = 8,
  parameter int PTRBITWIDTH  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ddc_flag,
  input  logic [DATABITWIDTH-1:0] ddc_i_data,
  input  logic [DATABITWIDTH-1:0] ddc_q_data,
  input  logic                    out_ready,
  input  logic                    clr_overflow,
  output logic [DATABITWIDTH-1:0] out_data,
  output logic                    out_valid,
  output logic                    out_iq_sel,
  output logic [PTRBITWIDTH:0]    fifo_level,
  output logic                    overflow
);

  localparam int                ENTRYBITS  = 2 * DATABITWIDTH;
  localparam logic [PTRBITWIDTH:0]   FULL_COUNT = (PTRBITWIDTH + 1)'(FIFODEPTH);
  localparam logic [PTRBITWIDTH:0]   CNT_ONE    = (PTRBITWIDTH + 1)'(1);
  localparam logic [PTRBITWIDTH-1:0] PTR_ONE    = PTRBITWIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEND_I = 2'd1,
    ST_SEND_Q = 2'd2
  } state_t;

  logic [ENTRYBITS-1:0] mem [FIFODEPTH];

  state_t                 state_q, state_d;
  logic [PTRBITWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTRBITWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTRBITWIDTH:0]   count_q, count_d;
  logic [ENTRYBITS-1:0]   hold_q, hold_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_iq_sel_q, out_iq_sel_d;
  logic                   overflow_q, overflow_d;

  logic fifo_empty;
  logic fifo_full;
  logic transfer;
  logic pop;
  logic push_acc;
  logic drop;

  always_comb begin
    state_d      = state_q;
    out_valid_d  = out_valid_q;
    out_iq_sel_d = out_iq_sel_q;
    pop          = 1'b0;

    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == FULL_COUNT);
    transfer   = out_valid_q & out_ready;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop          = 1'b1;
          state_d      = ST_SEND_I;
          out_valid_d  = 1'b1;
          out_iq_sel_d = 1'b0;
        end
      end
      ST_SEND_I: begin
        if (transfer) begin
          state_d      = ST_SEND_Q;
          out_iq_sel_d = 1'b1;
        end
      end
      ST_SEND_Q: begin
        if (transfer) begin
          // Refill straight from the FIFO so a waiting pair follows with no bubble.
          if (!fifo_empty) begin
            pop          = 1'b1;
            state_d      = ST_SEND_I;
            out_iq_sel_d = 1'b0;
          end else begin
            state_d      = ST_IDLE;
            out_valid_d  = 1'b0;
            out_iq_sel_d = 1'b0;
          end
        end
      end
      default: begin
        state_d      = ST_IDLE;
        out_valid_d  = 1'b0;
        out_iq_sel_d = 1'b0;
      end
    endcase

    // A pop frees the head slot this cycle, so a full FIFO can still take the new pair.
    push_acc = ddc_flag & (~fifo_full | pop);
    drop     = ddc_flag & ~push_acc;

    hold_d   = pop ? mem[rd_ptr_q] : hold_q;
    wr_ptr_d = push_acc ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

    count_d = count_q;
    case ({push_acc, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      hold_q       <= '0;
      out_valid_q  <= 1'b0;
      out_iq_sel_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      hold_q       <= hold_d;
      out_valid_q  <= out_valid_d;
      out_iq_sel_q <= out_iq_sel_d;
      overflow_q   <= overflow_d;
    end
  end

  // Storage needs no reset: pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (rst && push_acc) begin
      mem[wr_ptr_q] <= {ddc_i_data, ddc_q_data};
    end
  end

  assign out_data   = out_iq_sel_q ? hold_q[DATABITWIDTH-1:0] : hold_q[ENTRYBITS-1:DATABITWIDTH];
  assign out_valid  = out_valid_q;
  assign out_iq_sel = out_iq_sel_q;
  assign fifo_level = count_q;
  assign overflow   = overflow_q;

endmodule

// File: doc/ddc_out_formatter.md
# ddc_out_formatter

Output formatting stage placed directly downstream of the DDC core. It captures each decimated I/Q pair presented on `ddc_i_data`/`ddc_q_data` with `ddc_flag`, buffers the pairs in a small FIFO, and serialises them as I then Q words on a single `DATABITWIDTH` output bus with a valid/ready handshake. This decouples the bursty decimated DDC output from the external capture interface and reports lost samples through a sticky overflow flag.

## Interface
- `DATABITWIDTH`, 16, width of the I and Q samples and of `out_data`
- `FIFODEPTH`, 8, number of I/Q pairs the FIFO holds; must be a power of 2
- `PTRBITWIDTH`, 3, log2(`FIFODEPTH`)

- `clk`  in  1  system clock; all logic on the rising edge
- `rst`  in  1  synchronous, active-low reset
- `ddc_flag`  in  1  one-cycle strobe; the I/Q pair on the data inputs is valid this cycle
- `ddc_i_data`  in  DATABITWIDTH  I sample, two's complement
- `ddc_q_data`  in  DATABITWIDTH  Q sample, two's complement
- `out_ready`  in  1  downstream is able to accept `out_data` this cycle
- `clr_overflow`  in  1  clears the `overflow` flag
- `out_data`  out  DATABITWIDTH  serialised sample word
- `out_valid`  out  1  `out_data` is valid
- `out_iq_sel`  out  1  0 means `out_data` is I, 1 means `out_data` is Q
- `fifo_level`  out  PTRBITWIDTH+1  number of pairs currently stored in the FIFO, registered
- `overflow`  out  1  sticky flag: at least one pair has been dropped

## Operation
- **FIFO storage**
  - Each entry is {I,Q}, 2×DATABITWIDTH bits wide.
  - Write pointer and read pointer wrap modulo `FIFODEPTH`.
  - The FIFO is full when the count equals `FIFODEPTH` and empty when the count is 0.
- **Push**
  - A push is attempted when `ddc_flag`=1.
  - The push is accepted if the FIFO is not full, or if a pop happens in the same cycle.
  - Otherwise the pair is dropped and `overflow` is set.
- **Pop**
  - A pop moves the head entry into the holding register that drives the output.
  - When a push and a pop happen in the same cycle, the count is unchanged.
- **Read FSM: IDLE**
  - `out_valid`=0.
  - If the FIFO is non-empty: pop, load the holding register, drive `out_data`=I, `out_iq_sel`=0, `out_valid`=1, and go to SEND_I.
- **Read FSM: SEND_I**
  - On a transfer (`out_valid`&&`out_ready`): drive `out_data`=Q, `out_iq_sel`=1, and go to SEND_Q.
- **Read FSM: SEND_Q**, on a transfer:
  - If the FIFO is non-empty: pop, drive the new I with `out_iq_sel`=0, and go to SEND_I. This is back-to-back operation with no bubble.
  - Otherwise: `out_valid`=0 and go to IDLE.
- **Handshake**
  - While `out_valid`=1 and `out_ready`=0, `out_data` and `out_iq_sel` hold stable.
  - `out_valid` never drops without a transfer.
- **Overflow flag**
  - `overflow` is set on a dropped pair.
  - `clr_overflow` clears it.
  - If a drop and `clr_overflow` occur in the same cycle, set wins.
- **Data path**
  - No arithmetic is applied; samples pass bit-exact.

## Timing
- **Reset values**
  - `out_data`=0, `out_valid`=0, `out_iq_sel`=0, `fifo_level`=0, `overflow`=0.
  - FSM in IDLE, both pointers at 0.
- **Reset mid-operation**
  - All buffered and in-flight pairs are discarded.
  - `out_valid` is 0 in the first cycle after the reset edge.
- **Latency**
  - `ddc_flag` in cycle N (FIFO empty, IDLE) leads to `out_valid`=1 with I in cycle N+2, and Q in the cycle after the I transfer.
  - `fifo_level` reflects a push or pop in the cycle after the edge at which it occurs.
- **Throughput**
  - One word per cycle, so one pair per 2 cycles.
  - Sustained `ddc_flag` rate ≤ 1 per 2 cycles never overflows while `out_ready`=1.
- **Capacity**
  - Total buffered pairs = FIFODEPTH + 1, counting the holding register.

## Test plan
1. **Single pair.** After reset, `out_ready`=1, `ddc_flag` for one cycle with I=0x1234, Q=0xABCD.
   - Required: `out_valid` rises 2 cycles later with 0x1234/sel 0.
   - Next cycle: 0xABCD/sel 1.
   - Then `out_valid`=0 and `fifo_level`=0.
2. **Backpressure.** Same stimulus with `out_ready`=0 for 5 cycles after `out_valid` rises.
   - Required: `out_data`=0x1234 and sel=0 stable for all 5 cycles.
   - Q is presented only after the I transfer.
3. **Fill and overflow.** `out_ready`=0, 10 consecutive `ddc_flag` pulses with I=k, Q=0x100+k, k=1..10.
   - Required: pairs 1–9 accepted, `fifo_level`=8, pair 10 dropped, `overflow`=1.
   - Then `out_ready`=1: 18 transfers, I/Q of k=1..9 in order, no gaps.
4. **Back-to-back streaming.** `ddc_flag` every 2 cycles for 20 pairs, `out_ready`=1.
   - Required: `out_valid` continuously high after the first word.
   - Strict I,Q alternation, `fifo_level` ≤ 1, `overflow`=0.
5. **Overflow clear.** FIFO full; `clr_overflow` coincides with a dropped pair.
   - Required: `overflow` stays 1.
   - `clr_overflow` alone in the next cycle gives `overflow`=0.
6. **Reset mid-stream.** `rst`=0 while in SEND_Q with 3 pairs buffered.
   - Required: the next cycle shows `out_valid`=0, `fifo_level`=0, `overflow`=0.
   - After release, no pre-reset data is ever emitted.
